// File: rtl/warp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : warp_scheduler
//  Purpose  : Round-robin warp issue scheduler. Snoops instruction-buffer
//             writes to track occupied warp slots, gates each slot on the
//             active mask, a per-warp register scoreboard and a halt flag,
//             and loads one instruction per cycle into a registered
//             valid/ready issue slot toward the execute stage.
//  Revision : 1.0  initial release
// ============================================================================
module warp_scheduler #(
    parameter int         NUM_WARPS   = 4,
    parameter int         NUM_REGS    = 16,
    parameter logic [15:0] WRITES_REG = 16'h00FE,
    parameter logic [3:0] HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   buffer_write_en,
    input  logic [1:0]             warp_num_store,
    input  logic [4*NUM_WARPS-1:0] opcode_in,
    input  logic [4*NUM_WARPS-1:0] target_reg_in,
    input  logic [4*NUM_WARPS-1:0] address_reg_in,
    input  logic [4*NUM_WARPS-1:0] imm_short_in,
    input  logic [2*NUM_WARPS-1:0] array_id_in,
    input  logic [NUM_WARPS-1:0]   warp_active,
    input  logic                   wb_valid,
    input  logic [1:0]             wb_warp,
    input  logic [3:0]             wb_reg,
    input  logic                   issue_ready,
    output logic                   issue_valid,
    output logic [1:0]             issue_warp,
    output logic [3:0]             issue_opcode,
    output logic [3:0]             issue_target_reg,
    output logic [3:0]             issue_address_reg,
    output logic [3:0]             issue_imm_short,
    output logic [1:0]             issue_array_id,
    output logic [NUM_WARPS-1:0]   slot_consumed,
    output logic [NUM_WARPS-1:0]   warp_done
);

    // Warp ids are carried on 2-bit fields, so at most four warps are
    // addressable; the rotation arithmetic below uses one extra bit.
    localparam logic [2:0] c_num_warps = 3'(NUM_WARPS);

    // Slot occupancy, per-warp pending-write scoreboard and rotation pointer.
    logic [NUM_WARPS-1:0]                r_full;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0]  r_sb;
    logic [1:0]                          r_rr_ptr;

    logic [NUM_WARPS-1:0] w_elig;
    logic [NUM_WARPS-1:0] w_wr_onehot;
    logic [NUM_WARPS-1:0] w_sel_onehot;
    logic [1:0]           w_rot_idx [NUM_WARPS];
    logic                 w_can_load;
    logic                 w_sel_found;
    logic                 w_sel_valid;
    logic [1:0]           w_sel_idx;
    logic [3:0]           w_sel_opcode;
    logic [3:0]           w_sel_target;
    logic [3:0]           w_sel_address;
    logic [3:0]           w_sel_imm;
    logic [1:0]           w_sel_array_id;

    // The issue slot may take a new instruction when empty or draining.
    assign w_can_load  = ~issue_valid | issue_ready;
    assign w_sel_valid = w_can_load & w_sel_found;

    // Per-warp eligibility, write strobes and selection strobes.
    // The scoreboard is read from registered state only, so a writeback
    // unblocks a warp starting the cycle after it is presented.
    generate
        for (genvar w = 0; w < NUM_WARPS; w++) begin : g_warp
            assign w_elig[w] = r_full[w] & warp_active[w] & ~warp_done[w]
                             & ~r_sb[w][target_reg_in[4*w +: 4]]
                             & ~r_sb[w][address_reg_in[4*w +: 4]];
            assign w_wr_onehot[w]  = buffer_write_en & (warp_num_store == 2'(w));
            assign w_sel_onehot[w] = w_sel_valid & (w_sel_idx == 2'(w));
        end
    endgenerate

    // Candidate order for this cycle: rr_ptr, rr_ptr+1, ... wrapping at NUM_WARPS.
    generate
        for (genvar i = 0; i < NUM_WARPS; i++) begin : g_rot
            logic [2:0] w_sum;
            assign w_sum        = {1'b0, r_rr_ptr} + 3'(i);
            assign w_rot_idx[i] = (w_sum >= c_num_warps) ? 2'(w_sum - c_num_warps)
                                                         : w_sum[1:0];
        end
    endgenerate

    // Pick the first eligible warp in rotation order.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = 2'd0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (!w_sel_found && w_elig[w_rot_idx[i]]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = w_rot_idx[i];
            end
        end
    end

    // Route the selected warp's buffered fields toward the issue slot.
    always_comb begin
        w_sel_opcode   = 4'd0;
        w_sel_target   = 4'd0;
        w_sel_address  = 4'd0;
        w_sel_imm      = 4'd0;
        w_sel_array_id = 2'd0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            if (w_sel_idx == 2'(i)) begin
                w_sel_opcode   = opcode_in[4*i +: 4];
                w_sel_target   = target_reg_in[4*i +: 4];
                w_sel_address  = address_reg_in[4*i +: 4];
                w_sel_imm      = imm_short_in[4*i +: 4];
                w_sel_array_id = array_id_in[2*i +: 2];
            end
        end
    end

    // Slot occupancy: a write landing on the same edge as a selection keeps
    // the slot full, since the selected instruction is the older one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full <= '0;
        end else begin
            r_full <= (r_full & ~w_sel_onehot) | w_wr_onehot;
        end
    end

    // Scoreboard: writeback clears, issue of a register-writing opcode sets.
    // The hazard check prevents both from targeting the same bit at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sb <= '0;
        end else begin
            if (wb_valid) begin
                r_sb[wb_warp][wb_reg] <= 1'b0;
            end
            if (w_sel_valid && WRITES_REG[w_sel_opcode]) begin
                r_sb[w_sel_idx][w_sel_target] <= 1'b1;
            end
        end
    end

    // Halt tracking: a warp that issues HALT is retired until reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            warp_done <= '0;
        end else if (w_sel_valid && (w_sel_opcode == HALT_OPCODE)) begin
            warp_done[w_sel_idx] <= 1'b1;
        end
    end

    // Rotation pointer advances past the warp just selected.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr <= 2'd0;
        end else if (w_sel_valid) begin
            r_rr_ptr <= (w_sel_idx == 2'(NUM_WARPS - 1)) ? 2'd0 : w_sel_idx + 2'd1;
        end
    end

    // Issue slot: load on selection, empty when nothing is eligible, hold
    // everything stable while the execute stage back-pressures.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            issue_valid       <= 1'b0;
            issue_warp        <= 2'd0;
            issue_opcode      <= 4'd0;
            issue_target_reg  <= 4'd0;
            issue_address_reg <= 4'd0;
            issue_imm_short   <= 4'd0;
            issue_array_id    <= 2'd0;
            slot_consumed     <= '0;
        end else begin
            slot_consumed <= w_sel_onehot;
            if (w_can_load) begin
                issue_valid <= w_sel_found;
                if (w_sel_found) begin
                    issue_warp        <= w_sel_idx;
                    issue_opcode      <= w_sel_opcode;
                    issue_target_reg  <= w_sel_target;
                    issue_address_reg <= w_sel_address;
                    issue_imm_short   <= w_sel_imm;
                    issue_array_id    <= w_sel_array_id;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_warp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_warp_scheduler
//  Purpose  : Directed, table-driven self-checking bench for warp_scheduler.
//  Revision : 1.0  initial release
// ============================================================================
module tb_warp_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        buffer_write_en = 1'b0;
    logic [1:0]  warp_num_store = 2'd0;
    logic [15:0] opcode_in, target_reg_in, address_reg_in, imm_short_in;
    logic [7:0]  array_id_in;
    logic [3:0]  warp_active = 4'hF;
    logic        wb_valid = 1'b0;
    logic [1:0]  wb_warp = 2'd0;
    logic [3:0]  wb_reg = 4'd0;
    logic        issue_ready = 1'b1;
    logic        issue_valid;
    logic [1:0]  issue_warp;
    logic [3:0]  issue_opcode, issue_target_reg, issue_address_reg, issue_imm_short;
    logic [1:0]  issue_array_id;
    logic [3:0]  slot_consumed, warp_done;

    // Buffer contents seen by the scheduler; a write lands at its clock edge.
    logic [3:0] b_op [4];
    logic [3:0] b_tgt [4];
    logic [3:0] b_addr [4];

    int n_checks = 0;
    int n_fail   = 0;

    warp_scheduler dut (
        .clk               (clk),
        .reset             (reset),
        .buffer_write_en   (buffer_write_en),
        .warp_num_store    (warp_num_store),
        .opcode_in         (opcode_in),
        .target_reg_in     (target_reg_in),
        .address_reg_in    (address_reg_in),
        .imm_short_in      (imm_short_in),
        .array_id_in       (array_id_in),
        .warp_active       (warp_active),
        .wb_valid          (wb_valid),
        .wb_warp           (wb_warp),
        .wb_reg            (wb_reg),
        .issue_ready       (issue_ready),
        .issue_valid       (issue_valid),
        .issue_warp        (issue_warp),
        .issue_opcode      (issue_opcode),
        .issue_target_reg  (issue_target_reg),
        .issue_address_reg (issue_address_reg),
        .issue_imm_short   (issue_imm_short),
        .issue_array_id    (issue_array_id),
        .slot_consumed     (slot_consumed),
        .warp_done         (warp_done)
    );

    always #5 clk = ~clk;

    // Pack buffer arrays; immediate is warp+8 and array id is ~warp, fixed.
    always_comb begin
        opcode_in      = '0;
        target_reg_in  = '0;
        address_reg_in = '0;
        imm_short_in   = '0;
        array_id_in    = '0;
        for (int w = 0; w < 4; w++) begin
            opcode_in[4*w +: 4]      = b_op[w];
            target_reg_in[4*w +: 4]  = b_tgt[w];
            address_reg_in[4*w +: 4] = b_addr[w];
            imm_short_in[4*w +: 4]   = 4'(w + 8);
            array_id_in[2*w +: 2]    = ~2'(w);
        end
    end

    typedef struct packed {
        logic       wr;
        logic [1:0] ww;
        logic [3:0] wop;
        logic [3:0] wtgt;
        logic [3:0] waddr;
        logic [3:0] act;
        logic       rdy;
        logic       wbv;
        logic [1:0] wbw;
        logic [3:0] wbr;
        logic       ev;
        logic [1:0] ew;
        logic [3:0] eop;
        logic [3:0] etgt;
        logic [3:0] eaddr;
        logic [3:0] econs;
        logic [3:0] edone;
    } vec_t;

    vec_t tbl [$];

    function automatic vec_t mk(input int wr, input int ww, input int wop, input int wtgt,
                                input int waddr, input int act, input int rdy, input int wbv,
                                input int wbw, input int wbr, input int ev, input int ew,
                                input int eop, input int etgt, input int eaddr,
                                input int econs, input int edone);
        vec_t r;
        r.wr = 1'(wr);   r.ww = 2'(ww);     r.wop = 4'(wop);   r.wtgt = 4'(wtgt);
        r.waddr = 4'(waddr); r.act = 4'(act); r.rdy = 1'(rdy); r.wbv = 1'(wbv);
        r.wbw = 2'(wbw); r.wbr = 4'(wbr);   r.ev = 1'(ev);     r.ew = 2'(ew);
        r.eop = 4'(eop); r.etgt = 4'(etgt); r.eaddr = 4'(eaddr);
        r.econs = 4'(econs); r.edone = 4'(edone);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance one clock, land any write into the buffer model, settle.
    task automatic step();
        logic       wr;
        logic [1:0] ww;
        logic [3:0] op, tgt, addr;
        wr = buffer_write_en; ww = warp_num_store;
        op = pend_op; tgt = pend_tgt; addr = pend_addr;
        @(posedge clk);
        #1;
        if (wr) begin
            b_op[ww] = op; b_tgt[ww] = tgt; b_addr[ww] = addr;
        end
    endtask

    logic [3:0] pend_op = 4'd0, pend_tgt = 4'd0, pend_addr = 4'd0;

    task automatic drive(input vec_t v);
        buffer_write_en = v.wr;  warp_num_store = v.ww;
        pend_op = v.wop; pend_tgt = v.wtgt; pend_addr = v.waddr;
        warp_active = v.act; issue_ready = v.rdy;
        wb_valid = v.wbv; wb_warp = v.wbw; wb_reg = v.wbr;
    endtask

    function automatic logic [28:0] all_outs();
        return {issue_valid, issue_warp, issue_opcode, issue_target_reg, issue_address_reg,
                issue_imm_short, issue_array_id, slot_consumed, warp_done};
    endfunction

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, "_ctl"}, 32'({issue_valid, slot_consumed, warp_done}),
              32'({v.ev, v.econs, v.edone}));
        if (v.ev) begin
            check({tag, "_fields"},
                  32'({issue_warp, issue_opcode, issue_target_reg, issue_address_reg,
                       issue_imm_short, issue_array_id}),
                  32'({v.ew, v.eop, v.etgt, v.eaddr, 2'b10, v.ew, ~v.ew}));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < 4; w++) begin
            b_op[w] = 4'd0; b_tgt[w] = 4'd0; b_addr[w] = 4'd0;
        end

        //   wr ww op tg ad  act  rdy wbv wbw wbr | ev ew op tg ad cons done
        // Fill all four slots while inactive, then rotate 0,1,2,3.
        tbl.push_back(mk(1,0,8'h8,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,1,8'h9,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,2,8'hA,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,3,8'hB,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,0,8'h8,0,0, 4'h1,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,1,8'h9,0,0, 4'h2,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,2,8'hA,0,0, 4'h4,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,3,8'hB,0,0, 4'h8,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        // Warp0 writes R5, refill reading R5 stays blocked until writeback.
        tbl.push_back(mk(1,0,1,5,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,0,1,5,0, 4'h1,4'h0));
        tbl.push_back(mk(1,0,8,0,5,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 1,0,5, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,0,8,0,5, 4'h1,4'h0));
        // Writeback to an already-clear bit; warp1 writes R7.
        tbl.push_back(mk(1,1,2,7,0,    4'hF,1, 1,0,5, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,2,8'hC,0,0, 4'hF,1, 0,0,0, 1,1,2,7,0, 4'h2,4'h0));
        // Back-pressure for three cycles: slot held, warp2 waits.
        tbl.push_back(mk(0,0,0,0,0,    4'hF,0, 0,0,0, 1,1,2,7,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,0, 0,0,0, 1,1,2,7,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,0, 0,0,0, 1,1,2,7,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,2,8'hC,0,0, 4'h4,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        // Issue warp3 so the pointer wraps to 0.
        tbl.push_back(mk(1,3,8,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,3,8,0,0, 4'h8,4'h0));
        // Active mask 1011 skips warp2; warp3 issues HALT.
        tbl.push_back(mk(1,0,8'hD,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,1,8'hE,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,2,9,0,0,    4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(1,3,8'hF,0,0, 4'h0,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hB,1, 0,0,0, 1,0,8'hD,0,0, 4'h1,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hB,1, 0,0,0, 1,1,8'hE,0,0, 4'h2,4'h0));
        tbl.push_back(mk(0,0,0,0,0,    4'hB,1, 0,0,0, 1,3,8'hF,0,0, 4'h8,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hB,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));
        tbl.push_back(mk(1,3,8,0,0,    4'hB,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hB,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,2,9,0,0, 4'h4,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));
        // Write warp1 on the edge it is selected: new instruction follows.
        tbl.push_back(mk(1,1,8,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));
        tbl.push_back(mk(1,1,8'hA,0,0, 4'hF,1, 0,0,0, 1,1,8,0,0, 4'h2,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 1,1,8'hA,0,0, 4'h2,4'h8));
        tbl.push_back(mk(0,0,0,0,0,    4'hF,1, 0,0,0, 0,0,0,0,0, 4'h0,4'h8));

        // Power-on reset.
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(all_outs()), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            step();
            check_vec($sformatf("vec%0d", i), tbl[i]);
        end

        // Reset asserted while an instruction sits in the issue slot.
        drive(mk(1,0,8,0,0, 4'hF,1, 0,0,0, 0,0,0,0,0, 0,0));
        step();
        check("mid_pre_write", 32'({issue_valid, slot_consumed}), 32'd0);
        drive(mk(0,0,0,0,0, 4'hF,1, 0,0,0, 0,0,0,0,0, 0,0));
        step();
        check("mid_issued", 32'({issue_valid, issue_warp, slot_consumed, warp_done}),
              32'({1'b1, 2'd0, 4'h1, 4'h8}));
        #3;
        reset = 1'b0;
        #1;
        check("async_reset_now", 32'(all_outs()), 32'd0);
        @(posedge clk);
        #1;
        check("reset_held", 32'(all_outs()), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1,2,1,3,0, 4'hF,1, 0,0,0, 0,0,0,0,0, 0,0));
        step();
        check("post_reset_write", 32'({issue_valid, slot_consumed, warp_done}), 32'd0);
        drive(mk(0,0,0,0,0, 4'hF,1, 0,0,0, 0,0,0,0,0, 0,0));
        step();
        check("post_reset_issue",
              32'({issue_valid, issue_warp, issue_opcode, issue_target_reg, slot_consumed, warp_done}),
              32'({1'b1, 2'd2, 4'd1, 4'd3, 4'h4, 4'h0}));
        step();
        check("post_reset_idle", 32'({issue_valid, slot_consumed}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
